// File: rtl/timer_counter.sv
// Purpose : memory-mapped countdown timer (CTRL/PRESET/COUNT window) raising a level IRQ on expiry.
// Latency : reads combinational (0 cycles); writes take effect at the rising edge with WE=1.
// Backpr. : none; a write cycle freezes the count FSM for that cycle, so the bridge never stalls.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   Addr  - word address (byte address bits [31:2]); only [3:2] decoded
//   WE    - write strobe (full-word store to this instance)
//   Din   - write data
//   Dout  - read data, combinational from current register state
//   IRQ   - level interrupt request = irq_flag & CTRL.IM
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state_q;
    logic [3:0]  ctrl_q;        // {IM, Mode[1:0], Enable}
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;

    logic        enable;
    logic [1:0]  mode;
    logic        irq_mask;
    logic [1:0]  reg_sel;
    logic [31:0] count_dec_d;

    // Only the register-select bits matter; the rest of the address is
    // decoded by the bridge before WE reaches this instance.
    logic unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign enable      = ctrl_q[0];
    assign mode        = ctrl_q[2:1];
    assign irq_mask    = ctrl_q[3];
    assign reg_sel     = Addr[3:2];
    assign count_dec_d = count_q - 32'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'h0;
            preset_q   <= 32'h0;
            count_q    <= 32'h0;
            irq_flag_q <= 1'b0;
        end else if (WE) begin
            // Bus write: register update only, the count FSM holds this cycle.
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_q     <= Din[3:0];
                    irq_flag_q <= 1'b0;
                end
                REG_PRESET: preset_q <= Din;
                default: ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!enable) begin
                        // Pause: count holds, re-enable restarts from PRESET.
                        state_q <= S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_dec_d;
                    end else begin
                        // Covers COUNT==0 too, so PRESET=0 acts like PRESET=1.
                        count_q    <= 32'h0;
                        irq_flag_q <= 1'b1;
                        state_q    <= S_INT;
                    end
                end
                S_INT: begin
                    if (mode == MODE_RELOAD) begin
                        irq_flag_q <= 1'b0;
                    end else begin
                        // One-shot: flag stays set until software writes CTRL.
                        ctrl_q[0] <= 1'b0;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Dout = 32'h0;
        case (reg_sel)
            REG_CTRL:   Dout = {28'h0, ctrl_q};
            REG_PRESET: Dout = preset_q;
            REG_COUNT:  Dout = count_q;
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = irq_flag_q & irq_mask;

endmodule

// File: tb/tb_timer_counter.sv
// Purpose : self-checking bench for timer_counter using a cycle-stamped expectation queue.
// Latency : expectations are stamped with the edge index at which they must hold.
// Backpr. : n/a (bench drives the bus directly, one access per cycle).
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    localparam int SEL_IRQ = 4;

    typedef struct {
        string       tag;
        int          cyc;
        int          sel;      // 0..3 register offset index, SEL_IRQ for IRQ pin
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Insert keeping the queue ordered by cycle (stable for equal cycles).
    task automatic push(input string tag, input int c, input int sel, input logic [31:0] val);
        exp_t e;
        int   i;
        e.tag = tag;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic rd(input int sel, output logic [31:0] v);
        logic [31:0] ba;
        ba   = 32'h7F00 + 32'(sel * 4);
        Addr = ba[31:2];
        #1;
        v = Dout;
    endtask

    task automatic observe();
        exp_t        e;
        logic [31:0] v;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
            end else begin
                if (e.sel == SEL_IRQ) begin
                    #1;
                    v = {31'h0, IRQ};
                end else begin
                    rd(e.sel, v);
                end
                check(e.tag, v, e.val);
            end
        end
    endtask

    // Advance one rising edge, then compare everything due at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        WE = 1'b0;
        observe();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int sel, input logic [31:0] d);
        logic [31:0] ba;
        ba   = 32'h7F00 + 32'(sel * 4);
        Addr = ba[31:2];
        Din  = d;
        WE   = 1'b1;
        tick();
    endtask

    initial begin : main
        int          c0;
        logic [31:0] v;
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        WE       = 1'b0;
        Din      = 32'h0;
        Addr     = '0;

        // Reset state
        #3;
        rd(0, v); check("rst_ctrl", v, 32'h0);
        rd(2, v); check("rst_count", v, 32'h0);
        check("rst_irq", {31'h0, IRQ}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Reset mid-count
        wr(1, 32'd5);
        c0 = cyc + 1;
        push("pre_rst_count", c0 + 2, 2, 32'd5);
        wr(0, 32'h9);
        idle(2);
        reset = 1'b0;
        rd(0, v); check("arst_ctrl", v, 32'h0);
        rd(1, v); check("arst_preset", v, 32'h0);
        rd(2, v); check("arst_count", v, 32'h0);
        check("arst_irq", {31'h0, IRQ}, 32'h0);
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push("post_rst_count", cyc + i, 2, 32'h0);
            push("post_rst_irq", cyc + i, SEL_IRQ, 32'h0);
        end
        idle(10);

        // Register decode, then PRESET=0 with Enable
        c0 = cyc + 1;
        push("dec_count_wr", c0, 2, 32'h0);
        wr(2, 32'hFFFF_FFFF);
        c0 = cyc + 1;
        push("dec_off_c", c0, 3, 32'h0);
        push("dec_count", c0, 2, 32'h0);
        wr(3, 32'hFFFF_FFFF);
        c0 = cyc + 1;
        push("dec_ctrl", c0, 0, 32'hF);
        push("p0_irq_e2", c0 + 2, SEL_IRQ, 32'h0);
        push("p0_irq_e3", c0 + 3, SEL_IRQ, 32'h1);
        push("p0_ctrl_e4", c0 + 4, 0, 32'hE);
        push("p0_irq_e4", c0 + 4, SEL_IRQ, 32'h1);
        wr(0, 32'hFFFF_FFFF);
        idle(5);
        c0 = cyc + 1;
        push("p0_irq_clr", c0, SEL_IRQ, 32'h0);
        wr(0, 32'h0);
        idle(2);

        // One-shot
        wr(1, 32'd3);
        c0 = cyc + 1;
        push("os_count_e2", c0 + 2, 2, 32'd3);
        push("os_count_e3", c0 + 3, 2, 32'd2);
        push("os_count_e4", c0 + 4, 2, 32'd1);
        push("os_irq_e4", c0 + 4, SEL_IRQ, 32'h0);
        push("os_count_e5", c0 + 5, 2, 32'd0);
        push("os_irq_e5", c0 + 5, SEL_IRQ, 32'h1);
        push("os_ctrl_e5", c0 + 5, 0, 32'h9);
        push("os_ctrl_e6", c0 + 6, 0, 32'h8);
        push("os_irq_e8", c0 + 8, SEL_IRQ, 32'h1);
        push("os_count_e8", c0 + 8, 2, 32'd0);
        wr(0, 32'h9);
        idle(8);
        c0 = cyc + 1;
        push("os_irq_clr", c0, SEL_IRQ, 32'h0);
        push("os_count_idle", c0 + 2, 2, 32'd0);
        wr(0, 32'h8);
        idle(2);

        // Auto-reload: period N+3 = 5
        wr(1, 32'd2);
        c0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push("ar_irq_pre", c0 + 3 + 5 * k, SEL_IRQ, 32'h0);
            push("ar_irq_hit", c0 + 4 + 5 * k, SEL_IRQ, 32'h1);
            push("ar_irq_post", c0 + 5 + 5 * k, SEL_IRQ, 32'h0);
            push("ar_count_reload", c0 + 2 + 5 * k, 2, 32'd2);
            push("ar_count_zero", c0 + 4 + 5 * k, 2, 32'd0);
        end
        wr(0, 32'hB);
        idle(16);
        wr(0, 32'h0);
        idle(3);

        // Masked interrupt
        wr(1, 32'd4);
        c0 = cyc + 1;
        push("mask_count_e5", c0 + 5, 2, 32'd1);
        push("mask_count_e6", c0 + 6, 2, 32'd0);
        push("mask_irq_e6", c0 + 6, SEL_IRQ, 32'h0);
        push("mask_irq_e7", c0 + 7, SEL_IRQ, 32'h0);
        push("mask_ctrl_e7", c0 + 7, 0, 32'h0);
        wr(0, 32'h1);
        idle(8);

        // Pause at COUNT=2, then re-enable restarts from PRESET
        c0 = cyc + 1;
        push("pause_count_e4", c0 + 4, 2, 32'd2);
        push("pause_count_e5", c0 + 5, 2, 32'd2);
        push("pause_count_e7", c0 + 7, 2, 32'd2);
        push("pause_count_e9", c0 + 9, 2, 32'd2);
        wr(0, 32'h1);
        idle(4);
        wr(0, 32'h0);
        idle(4);
        c0 = cyc + 1;
        push("resume_count_e1", c0 + 1, 2, 32'd2);
        push("resume_count_e2", c0 + 2, 2, 32'd4);
        push("resume_count_e3", c0 + 3, 2, 32'd3);
        wr(0, 32'h1);
        idle(3);
        wr(0, 32'h0);
        idle(3);

        // Write collision on the expiry edge
        wr(1, 32'd3);
        c0 = cyc + 1;
        push("col_count_e4", c0 + 4, 2, 32'd1);
        push("col_count_e5", c0 + 5, 2, 32'd1);
        push("col_irq_e5", c0 + 5, SEL_IRQ, 32'h0);
        push("col_preset_e5", c0 + 5, 1, 32'd7);
        push("col_count_e6", c0 + 6, 2, 32'd0);
        push("col_irq_e6", c0 + 6, SEL_IRQ, 32'h1);
        wr(0, 32'h9);
        idle(4);
        wr(1, 32'd7);
        idle(3);
        c0 = cyc + 1;
        push("col_irq_clr", c0, SEL_IRQ, 32'h0);
        push("col_count_re1", c0 + 1, 2, 32'd0);
        push("col_count_re2", c0 + 2, 2, 32'd7);
        push("col_count_re3", c0 + 3, 2, 32'd6);
        wr(0, 32'h9);
        idle(3);
        idle(2);

        // Anything left in the queue was never compared.
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_unreached"}, 32'(cyc), 32'(e.cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer: the peripheral on the far side of the system bridge's timer port. It provides a 3-register window (CTRL, PRESET, COUNT) and raises an interrupt request when the count expires. Two instances sit at base 0x7F00 and 0x7F10. Each instance takes word address, write enable and write data from the bridge, and returns read data to it.

## Interface
- none (register layout and widths are fixed)

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- Addr  in  30  word address (byte address [31:2]); only Addr[3:2] decoded
- WE  in  1  write strobe; the bridge asserts it only for full-word stores to this instance
- Din  in  32  write data
- Dout  out  32  read data, combinational from current register state
- IRQ  out  1  interrupt request to the CPU, level

## Operation
- Register map (Addr[3:2]):
  - 0: CTRL; bit0 Enable, bits[2:1] Mode, bit3 IM (interrupt mask); bits[31:4] read 0, writes ignored.
  - 1: PRESET; 32-bit R/W.
  - 2: COUNT; read-only, writes ignored.
  - 3: reads 0, writes ignored.
- Mode 1 is auto-reload. Any other Mode value (0, 2, 3) is one-shot.
- IRQ = irq_flag & CTRL.IM.
- State machine states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, Enable=0: go to IDLE; COUNT holds its value (pause).
  - CNT, Enable=1, COUNT > 1: COUNT <= COUNT-1.
  - CNT, Enable=1, COUNT <= 1: COUNT <= 0; irq_flag <= 1; go to INT.
  - INT, one-shot: CTRL.Enable <= 0; go to IDLE; irq_flag stays 1.
  - INT, auto-reload: irq_flag <= 0; go to IDLE. The timer reloads and restarts on its own.
- Write cycles (WE=1):
  - The register is updated.
  - The FSM is frozen for that cycle: state and COUNT are unchanged. The CPU write wins over any FSM update of CTRL.
  - A write to CTRL also clears irq_flag. This is the only way to clear a one-shot interrupt.
  - Writing PRESET does not affect COUNT until the next LOAD.
- Re-enabling after a pause always goes IDLE→LOAD, so the count restarts from PRESET and does not resume.
- Arithmetic: 32-bit unsigned. COUNT never wraps below 0. PRESET=0 behaves as PRESET=1.

## Timing
- Reset (reset=0, async): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0. Dout reflects the zeroed registers.
- Reset asserted mid-count or during INT aborts immediately. After release the timer stays in IDLE until Enable is written.
- Read latency: 0 cycles. Dout is valid in the same cycle Addr is presented, and shows post-edge values after a write.
- Write latency: the register changes at the rising edge where WE=1.
- Let E0 be the edge that writes Enable=1 with PRESET=N≥1, and no further writes occur:
  - E1: IDLE→LOAD.
  - E2: COUNT=N, state CNT.
  - E(N+1): COUNT=1.
  - E(N+2): COUNT=0, irq_flag=1; IRQ rises if IM=1.
- One-shot: E(N+3) clears Enable. IRQ stays high until the next CTRL write.
- Auto-reload: IRQ is high for exactly 1 cycle. Period between IRQ rising edges is N+3 cycles.
- Simultaneous events:
  - A write to any register on the expiry edge freezes the FSM. Expiry happens one edge later.
  - A CTRL write on the INT edge overrides the FSM's Enable clear.

## Test plan
- Reset: drive reset=0 mid-count (COUNT=5, Enable=1), release → all registers read 0, IRQ=0, COUNT stays 0 for 10 cycles.
- One-shot: PRESET=3, CTRL=0x9 → COUNT reads 3,2,1,0 on edges E2..E5. IRQ=1 from E5 and holds; CTRL reads 0x8 after E6. Write CTRL=0x8 → IRQ=0 next edge.
- Auto-reload: PRESET=2, CTRL=0xB → IRQ is a 1-cycle pulse at E4, E9, E14 (period 5); COUNT reloads to 2 each period.
- Mask and pause: CTRL=0x1 (IM=0), PRESET=4 → IRQ stays 0 at expiry while COUNT=0. Separately, clear Enable at COUNT=2 → COUNT holds 2; re-enable → COUNT reloads to 4.
- Register decode: write 0xFFFFFFFF to CTRL, COUNT and offset 0xC → CTRL reads 0xF, COUNT unchanged, offset 0xC reads 0. PRESET=0 with Enable → IRQ at E3.
- Write collision: write PRESET on the edge COUNT would reach 0 → COUNT stays 1 that cycle and expires one edge later; the new PRESET is used only at the next LOAD.
